// File: rtl/i2s_codec_if.sv
// rtl/i2s_codec_if.sv - Philips I2S master: BCLK/LRCK generation, tx holding register, rx pair capture.
module i2s_codec_if #(
    parameter int DATA_W    = 16,
    parameter int BCLK_HALF = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] tx_l,
    input  logic [DATA_W-1:0] tx_r,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic [DATA_W-1:0] rx_l,
    output logic [DATA_W-1:0] rx_r,
    output logic              rx_valid,
    output logic              i2s_bclk,
    output logic              i2s_lrck,
    output logic              i2s_dacdat,
    input  logic              i2s_adcdat
);

    localparam int DIV_W = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BCLK_HALF - 1);
    localparam logic [4:0] LAST_P = 5'(DATA_W);

    logic [DIV_W-1:0]  div_cnt;
    logic [5:0]        bit_cnt;
    logic              hold_full;
    logic [DATA_W-1:0] hold_l, hold_r;
    logic [DATA_W-1:0] sh_l, sh_r;
    logic [DATA_W-1:0] rx_sh_l, rx_sh_r;
    logic              rx_armed;

    logic              div_tc, fall_ev, rise_ev, frame_start, transfer;
    logic [5:0]        bit_nxt;
    logic [4:0]        p_nxt, p_cur;
    logic [DATA_W-1:0] rx_shr_nxt;

    assign div_tc      = en && (div_cnt == DIV_MAX);
    assign fall_ev     = div_tc && i2s_bclk;
    assign rise_ev     = div_tc && !i2s_bclk;
    assign bit_nxt     = bit_cnt + 6'd1;
    assign p_nxt       = bit_nxt[4:0];
    assign p_cur       = bit_cnt[4:0];
    assign frame_start = fall_ev && (bit_cnt == 6'd63);
    assign transfer    = tx_valid && tx_ready;
    assign rx_shr_nxt  = (rx_sh_r << 1) | DATA_W'(i2s_adcdat);

    // Holding register; tx_ready mirrors "empty" but stays low during reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_full   <= 1'b0;
            hold_l      <= '0;
            hold_r      <= '0;
            tx_ready    <= 1'b0;
            tx_underrun <= 1'b0;
        end else begin
            tx_underrun <= frame_start && !hold_full;
            if (transfer) begin
                hold_l    <= tx_l;
                hold_r    <= tx_r;
                hold_full <= 1'b1;
                tx_ready  <= 1'b0;
            end else if (frame_start) begin
                hold_full <= 1'b0;
                tx_ready  <= 1'b1;
            end else begin
                tx_ready  <= !hold_full;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt    <= '0;
            i2s_bclk   <= 1'b0;
            bit_cnt    <= 6'd63;
            i2s_lrck   <= 1'b0;
            i2s_dacdat <= 1'b0;
            sh_l       <= '0;
            sh_r       <= '0;
        end else if (!en) begin
            div_cnt    <= '0;
            i2s_bclk   <= 1'b0;
            bit_cnt    <= 6'd63;
            i2s_lrck   <= 1'b0;
            i2s_dacdat <= 1'b0;
        end else if (div_tc) begin
            div_cnt  <= '0;
            i2s_bclk <= !i2s_bclk;
            if (i2s_bclk) begin
                bit_cnt    <= bit_nxt;
                i2s_lrck   <= bit_nxt[5];
                i2s_dacdat <= 1'b0;
                // Slot position 0 is the delay bit, so loading here costs no output bit.
                if (frame_start) begin
                    sh_l <= hold_full ? hold_l : '0;
                    sh_r <= hold_full ? hold_r : '0;
                end else if (p_nxt != 5'd0 && p_nxt <= LAST_P) begin
                    if (bit_nxt[5]) begin
                        i2s_dacdat <= sh_r[DATA_W-1];
                        sh_r       <= sh_r << 1;
                    end else begin
                        i2s_dacdat <= sh_l[DATA_W-1];
                        sh_l       <= sh_l << 1;
                    end
                end
            end
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // rx_armed blocks capture during the idle bit_cnt=63 slot before the first frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_sh_l  <= '0;
            rx_sh_r  <= '0;
            rx_l     <= '0;
            rx_r     <= '0;
            rx_valid <= 1'b0;
            rx_armed <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            if (!en) begin
                rx_armed <= 1'b0;
                rx_sh_l  <= '0;
                rx_sh_r  <= '0;
            end else if (frame_start) begin
                rx_armed <= 1'b1;
            end else if (rise_ev && rx_armed && p_cur != 5'd0 && p_cur <= LAST_P) begin
                if (bit_cnt[5]) begin
                    rx_sh_r <= rx_shr_nxt;
                    if (p_cur == LAST_P) begin
                        rx_l     <= rx_sh_l;
                        rx_r     <= rx_shr_nxt;
                        rx_valid <= 1'b1;
                    end
                end else begin
                    rx_sh_l <= (rx_sh_l << 1) | DATA_W'(i2s_adcdat);
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_codec_if.sv
// tb/tb_i2s_codec_if.sv - randomized/directed bench for i2s_codec_if with a time-based frame model.
module tb_i2s_codec_if;

    localparam int DW = 16;
    localparam int BH = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [DW-1:0] tx_l = '0, tx_r = '0;
    logic          tx_valid = 1'b0;
    logic          tx_ready, tx_underrun;
    logic [DW-1:0] rx_l, rx_r;
    logic          rx_valid, i2s_bclk, i2s_lrck, i2s_dacdat, i2s_adcdat;

    assign i2s_adcdat = i2s_dacdat;

    i2s_codec_if #(.DATA_W(DW), .BCLK_HALF(BH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en),
        .tx_l(tx_l), .tx_r(tx_r), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_underrun(tx_underrun), .rx_l(rx_l), .rx_r(rx_r), .rx_valid(rx_valid),
        .i2s_bclk(i2s_bclk), .i2s_lrck(i2s_lrck), .i2s_dacdat(i2s_dacdat),
        .i2s_adcdat(i2s_adcdat)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Model: everything follows from t, the count of enabled clk edges since start.
    int            t = 0;
    int            fs_cnt = 0;
    logic          hold_full_m = 1'b0;
    logic [DW-1:0] hold_l_m = '0, hold_r_m = '0, cur_l_m = '0, cur_r_m = '0;
    logic          e_ready = 1'b0, e_under = 1'b0, e_rxv = 1'b0;
    logic [DW-1:0] e_rxl = '0, e_rxr = '0;

    function automatic int falls(input int tt);
        return (tt / BH) / 2;
    endfunction

    function automatic int bitc(input int tt);
        return (63 + falls(tt)) % 64;
    endfunction

    function automatic int m_bc();
        return (falls(t) == 0) ? -1 : bitc(t);
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            t = 0; hold_full_m = 1'b0; e_ready = 1'b0; e_under = 1'b0;
            e_rxv = 1'b0; e_rxl = '0; e_rxr = '0;
        end else begin : step
            int   f_old;
            logic xfer;
            f_old   = falls(t);
            xfer    = tx_valid && e_ready;
            e_under = 1'b0;
            e_rxv   = 1'b0;
            t = en ? t + 1 : 0;
            if (en && falls(t) != f_old && falls(t) % 64 == 1) begin
                fs_cnt++;
                if (hold_full_m) begin
                    cur_l_m = hold_l_m; cur_r_m = hold_r_m; hold_full_m = 1'b0;
                end else begin
                    cur_l_m = '0; cur_r_m = '0; e_under = 1'b1;
                end
            end
            if (xfer) begin
                hold_l_m = tx_l; hold_r_m = tx_r; hold_full_m = 1'b1;
            end
            e_ready = !hold_full_m;
            if (en && t % (2 * BH) == BH && falls(t) >= 1 && bitc(t) == 32 + DW) begin
                e_rxv = 1'b1; e_rxl = cur_l_m; e_rxr = cur_r_m;
            end
        end
    end

    int under_q[$], rxv_q[$], bclk_q[$], lrck_q[$];
    int dac_ones = 0;
    logic prev_b = 1'b0, prev_lr = 1'b0;

    initial forever begin
        @(negedge clk);
        cyc++;
        begin : cmp
            int            f, bc, p;
            logic          e_b, e_lr, e_d;
            logic [DW-1:0] w;
            e_b  = ((t / BH) % 2) == 1;
            f    = falls(t);
            e_lr = 1'b0;
            e_d  = 1'b0;
            if (f > 0) begin
                bc   = bitc(t);
                p    = bc % 32;
                e_lr = bc >= 32;
                w    = (bc >= 32) ? cur_r_m : cur_l_m;
                if (p >= 1 && p <= DW) e_d = w[DW-p];
            end
            chk("bclk", i2s_bclk, e_b);
            chk("lrck", i2s_lrck, e_lr);
            chk("dacdat", i2s_dacdat, e_d);
            chk("tx_ready", tx_ready, e_ready);
            chk("tx_underrun", tx_underrun, e_under);
            chk("rx_valid", rx_valid, e_rxv);
            chk("rx_l", rx_l, e_rxl);
            chk("rx_r", rx_r, e_rxr);
        end
        if (tx_underrun) under_q.push_back(cyc);
        if (rx_valid) rxv_q.push_back(cyc);
        if (i2s_bclk && !prev_b) bclk_q.push_back(cyc);
        if (i2s_lrck && !prev_lr) lrck_q.push_back(cyc);
        if (i2s_dacdat) dac_ones++;
        prev_b  = i2s_bclk;
        prev_lr = i2s_lrck;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_rxv(input string nm);
        int n0;
        n0 = rxv_q.size();
        for (int i = 0; i < 600 && rxv_q.size() == n0; i++) tick(1);
        chk(nm, rxv_q.size() != n0, 1);
    endtask

    task automatic wait_under(input string nm);
        int n0;
        n0 = under_q.size();
        for (int i = 0; i < 600 && under_q.size() == n0; i++) tick(1);
        chk(nm, under_q.size() != n0, 1);
    endtask

    task automatic wait_bc(input int b, input string nm);
        for (int i = 0; i < 400 && m_bc() != b; i++) tick(1);
        chk(nm, m_bc() == b, 1);
    endtask

    task automatic send(input logic [DW-1:0] l, input logic [DW-1:0] r);
        tx_l = l; tx_r = r; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        tx_l = DW'($urandom); tx_r = DW'($urandom);
    endtask

    initial begin
        int n_xfer, fs0, u0, n0;
        logic r;

        tick(3);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_bclk", i2s_bclk, 0);
        chk("rst_rx_valid", rx_valid, 0);
        rst_n = 1'b1;
        tick(1);
        chk("ready_after_reset", tx_ready, 1);

        // Loopback of one held pair, then free-running underrun frames
        send(16'hA55A, 16'h1234);
        chk("ready_drops", tx_ready, 0);
        en = 1'b1;
        wait_rxv("first_rx_timeout");
        chk("rx_l_first", rx_l, 32'hA55A);
        chk("rx_r_first", rx_r, 32'h1234);
        chk("no_underrun_first", under_q.size(), 0);
        wait_rxv("second_rx_timeout");
        chk("rxv_spacing", rxv_q[1] - rxv_q[0], 256);
        chk("rx_l_zero", rx_l, 0);
        dac_ones = 0;
        u0 = under_q.size();
        tick(768);
        chk("underrun_count", under_q.size() - u0, 3);
        for (int i = 1; i < under_q.size(); i++)
            chk("underrun_spacing", under_q[i] - under_q[i-1], 256);
        chk("dac_quiet", dac_ones, 0);
        chk("bclk_period", bclk_q[bclk_q.size()-1] - bclk_q[bclk_q.size()-2], 4);
        chk("lrck_period", lrck_q[lrck_q.size()-1] - lrck_q[lrck_q.size()-2], 256);

        // Continuous offer with an incrementing pair
        tx_l = 16'h0100; tx_r = 16'h8000; tx_valid = 1'b1;
        n_xfer = 0; fs0 = fs_cnt; u0 = under_q.size();
        for (int i = 0; i < 1024; i++) begin
            r = tx_ready;
            tick(1);
            if (r) begin
                n_xfer++;
                tx_l = tx_l + 1'b1;
                tx_r = tx_r + 1'b1;
            end
        end
        tx_valid = 1'b0;
        chk("xfer_per_frame", n_xfer, (fs_cnt - fs0) + (hold_full_m ? 1 : 0));
        chk("no_underrun_stream", under_q.size() - u0, 0);

        // Transfer on the same clk as an empty-register frame start
        wait_under("drain_timeout");
        tick(255);
        tx_l = 16'h0F0F; tx_r = 16'hF0F0; tx_valid = 1'b1;
        tick(1);
        tx_valid = 1'b0;
        chk("coincide_underrun", tx_underrun, 1);
        chk("coincide_ready", tx_ready, 0);
        wait_rxv("coincide_rx0_timeout");
        chk("coincide_rx0", rx_l, 0);
        wait_rxv("coincide_rx1_timeout");
        chk("coincide_rx_l", rx_l, 32'h0F0F);
        chk("coincide_rx_r", rx_r, 32'hF0F0);

        // Abort at bit_cnt=40 with a pair held, then restart
        wait_bc(35, "bc35_timeout");
        send(16'h1357, 16'h2468);
        wait_bc(40, "bc40_timeout");
        en = 1'b0;
        n0 = rxv_q.size();
        tick(300);
        chk("abort_no_rxv", rxv_q.size() - n0, 0);
        chk("hold_kept", tx_ready, 0);
        en = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            chk("restart_wait", tx_ready, 0);
        end
        tick(1);
        chk("restart_fs_4clk", tx_ready, 1);
        wait_rxv("restart_rx_timeout");
        chk("restart_rx_l", rx_l, 32'h1357);
        chk("restart_rx_r", rx_r, 32'h2468);

        // Asynchronous reset pulse mid-frame with a pair held
        wait_bc(10, "bc10_timeout");
        send(DW'($urandom), DW'($urandom));
        wait_bc(20, "bc20_timeout");
        #2 rst_n = 1'b0;
        #1;
        chk("async_bclk", i2s_bclk, 0);
        chk("async_lrck", i2s_lrck, 0);
        chk("async_dac", i2s_dacdat, 0);
        chk("async_rx_l", rx_l, 0);
        chk("async_rx_r", rx_r, 0);
        chk("async_rxv", rx_valid, 0);
        chk("async_under", tx_underrun, 0);
        chk("async_ready", tx_ready, 0);
        rst_n = 1'b1;
        tick(1);
        chk("async_ready_after", tx_ready, 1);
        wait_under("post_reset_underrun_timeout");
        tick(50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
